turn_signal_sched: RTL and testbench

TURN_SIGNAL_SCHED -- requirements
Module: turn_signal_sched

---
 rtl/turn_signal_sched.sv | 129 ++++++++++++
 tb/tb_turn_signal_sched.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/turn_signal_sched.sv
// rtl/turn_signal_sched.sv - turn-signal frame scheduler: switch sync/debounce, arbitration, STEP timing
// Optional brake path enabled by defining TURN_SIGNAL_SCHED_BRAKE_EN.
module turn_signal_sched #(
  parameter int DIV       = 12500000,
  parameter int DB_CYCLES = 4
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       SW_LEFT,
  input  logic       SW_RIGHT,
  input  logic       SW_HAZ,
  input  logic       SW_BRAKE,
  output logic       LEFT,
  output logic       RIGHT,
  output logic       HAZ,
  output logic       STEP,
  output logic       BRAKE_OUT,
  output logic [1:0] MODE
);

  localparam logic [1:0] MODE_IDLE   = 2'd0;
  localparam logic [1:0] MODE_LEFT   = 2'd1;
  localparam logic [1:0] MODE_RIGHT  = 2'd2;
  localparam logic [1:0] MODE_HAZARD = 2'd3;

  localparam logic [23:0] PRESC_LAST = 24'(DIV - 1);
  localparam logic [7:0]  DB_LAST    = 8'(DB_CYCLES - 1);

  localparam int CH_LEFT  = 0;
  localparam int CH_RIGHT = 1;
  localparam int CH_HAZ   = 2;

`ifdef TURN_SIGNAL_SCHED_BRAKE_EN
  localparam int NCH = 4;
`else
  localparam int NCH = 3;
`endif

  logic [NCH-1:0] raw;
  logic [NCH-1:0] sync1;
  logic [NCH-1:0] sync2;
  logic [NCH-1:0] db;
  logic [7:0]     db_cnt [NCH];

`ifdef TURN_SIGNAL_SCHED_BRAKE_EN
  assign raw       = {SW_BRAKE, SW_HAZ, SW_RIGHT, SW_LEFT};
  assign BRAKE_OUT = db[3];
`else
  logic unused_brake;
  assign unused_brake = SW_BRAKE;
  assign raw          = {SW_HAZ, SW_RIGHT, SW_LEFT};
  assign BRAKE_OUT    = 1'b0;
`endif

  // Each channel flips only after DB_CYCLES back-to-back disagreeing samples.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      sync1 <= '0;
      sync2 <= '0;
      db    <= '0;
      for (int i = 0; i < NCH; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int i = 0; i < NCH; i++) begin
        if (sync2[i] != db[i]) begin
          if (db_cnt[i] == DB_LAST) begin
            db[i]     <= sync2[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 8'd1;
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  logic [1:0]  arb;
  logic [1:0]  mode_q;
  logic [1:0]  next_mode;
  logic [1:0]  phase;
  logic [23:0] presc;
  logic        frame_end;

  always_comb begin
    arb = MODE_IDLE;
    if (db[CH_HAZ] || (db[CH_LEFT] && db[CH_RIGHT])) arb = MODE_HAZARD;
    else if (db[CH_LEFT])                            arb = MODE_LEFT;
    else if (db[CH_RIGHT])                           arb = MODE_RIGHT;
  end

  assign MODE      = mode_q;
  assign STEP      = (mode_q != MODE_IDLE) && (presc == PRESC_LAST);
  assign frame_end = STEP && (phase == 2'd3);

  // Mode is latched from idle or at a frame boundary, otherwise frozen.
  always_comb begin
    next_mode = mode_q;
    if (mode_q == MODE_IDLE || frame_end) next_mode = arb;
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      mode_q <= MODE_IDLE;
      LEFT   <= 1'b0;
      RIGHT  <= 1'b0;
      HAZ    <= 1'b0;
      presc  <= '0;
      phase  <= '0;
    end else begin
      mode_q <= next_mode;
      LEFT   <= (next_mode == MODE_LEFT);
      RIGHT  <= (next_mode == MODE_RIGHT);
      HAZ    <= (next_mode == MODE_HAZARD);
      if (mode_q == MODE_IDLE || next_mode == MODE_IDLE) begin
        presc <= '0;
        phase <= '0;
      end else if (STEP) begin
        presc <= '0;
        phase <= phase + 2'd1;
      end else begin
        presc <= presc + 24'd1;
      end
    end
  end

endmodule

// File: tb/tb_turn_signal_sched.sv
// tb/tb_turn_signal_sched.sv - self-checking bench for turn_signal_sched
// Honours TURN_SIGNAL_SCHED_BRAKE_EN for the expected brake behaviour.
module tb_turn_signal_sched;

  localparam int DIV = 4;
  localparam int DB  = 3;

`ifdef TURN_SIGNAL_SCHED_BRAKE_EN
  localparam bit BRAKE_EN = 1'b1;
`else
  localparam bit BRAKE_EN = 1'b0;
`endif

  logic       CLOCK    = 1'b0;
  logic       RESET    = 1'b1;
  logic       SW_LEFT  = 1'b0;
  logic       SW_RIGHT = 1'b0;
  logic       SW_HAZ   = 1'b0;
  logic       SW_BRAKE = 1'b0;
  logic       LEFT, RIGHT, HAZ, STEP, BRAKE_OUT;
  logic [1:0] MODE;

  int passed = 0;
  int total  = 0;

  // Reference model: switch seen two edges late, run-length debounce,
  // and a frame timer counting cycles since the mode was loaded.
  logic [3:0] m_s1 = '0;
  logic [3:0] m_s2 = '0;
  logic [3:0] m_db = '0;
  int         m_run [4] = '{0, 0, 0, 0};
  int         m_mode = 0;
  int         m_t = 0;

  turn_signal_sched #(.DIV(DIV), .DB_CYCLES(DB)) dut (
    .CLOCK(CLOCK), .RESET(RESET),
    .SW_LEFT(SW_LEFT), .SW_RIGHT(SW_RIGHT), .SW_HAZ(SW_HAZ), .SW_BRAKE(SW_BRAKE),
    .LEFT(LEFT), .RIGHT(RIGHT), .HAZ(HAZ), .STEP(STEP),
    .BRAKE_OUT(BRAKE_OUT), .MODE(MODE)
  );

  always #5 CLOCK = ~CLOCK;

  function automatic int arbitrate(input logic [3:0] d);
    if (d[2] || (d[0] && d[1])) return 3;
    if (d[0]) return 1;
    if (d[1]) return 2;
    return 0;
  endfunction

  function automatic logic [6:0] exp_vec();
    logic stp;
    stp = (m_mode != 0) && ((m_t % DIV) == DIV - 1);
    return {2'(m_mode), m_mode == 1, m_mode == 2, m_mode == 3, stp, BRAKE_EN & m_db[3]};
  endfunction

  task automatic tick();
    logic [3:0] raw;
    logic [3:0] sync_now;
    int         arb;
    bit         frame_end;
    raw = {SW_BRAKE, SW_HAZ, SW_RIGHT, SW_LEFT};
    @(posedge CLOCK);
    if (RESET) begin
      m_s1 = '0; m_s2 = '0; m_db = '0;
      for (int c = 0; c < 4; c++) m_run[c] = 0;
      m_mode = 0; m_t = 0;
    end else begin
      arb       = arbitrate(m_db);
      frame_end = (m_mode != 0) && (m_t == 4 * DIV - 1);
      sync_now  = m_s2;
      m_s2      = m_s1;
      m_s1      = raw;
      for (int c = 0; c < 4; c++) begin
        if (sync_now[c] != m_db[c]) begin
          m_run[c]++;
          if (m_run[c] == DB) begin
            m_db[c]  = sync_now[c];
            m_run[c] = 0;
          end
        end else begin
          m_run[c] = 0;
        end
      end
      if (m_mode == 0 || frame_end) begin
        m_mode = arb;
        m_t    = 0;
      end else begin
        m_t++;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    SW_LEFT = 0; SW_RIGHT = 0; SW_HAZ = 0; SW_BRAKE = 0;
    tick();
    tick();
    RESET = 1'b0;
  endtask

  task automatic test_reset();
    logic [6:0] got;
    RESET = 1'b1;
    {SW_BRAKE, SW_HAZ, SW_RIGHT, SW_LEFT} = 4'($urandom);
    repeat (3) tick();
    got = {MODE, LEFT, RIGHT, HAZ, STEP, BRAKE_OUT};
    total++;
    if (got !== 7'b0) $display("FAIL reset_state got=%b want=0000000", got);
    else passed++;
    do_reset();
  endtask

  task automatic test_left_timing();
    do_reset();
    SW_LEFT = 1'b1;
    for (int k = 1; k <= 22; k++) begin
      tick();
      if (k == 5) begin
        total++;
        if (MODE !== 2'd0) $display("FAIL left_mode_c5 got=%0d want=0", MODE);
        else passed++;
      end
      if (k == 6 || k == 22) begin
        total++;
        if (MODE !== 2'd1 || LEFT !== 1'b1)
          $display("FAIL left_mode_c%0d got mode=%0d left=%b want mode=1 left=1", k, MODE, LEFT);
        else passed++;
      end
      total++;
      if (STEP !== (k == 9 || k == 13 || k == 17 || k == 21))
        $display("FAIL left_step_c%0d got=%b want=%b", k, STEP, (k == 9 || k == 13 || k == 17 || k == 21));
      else passed++;
    end
  endtask

  task automatic test_glitch();
    bit bad;
    bad = 0;
    do_reset();
    for (int k = 0; k < 36; k++) begin
      SW_LEFT = ((k % 3) < 2);
      tick();
      if (MODE !== 2'd0 || STEP !== 1'b0) bad = 1;
    end
    total++;
    if (bad) $display("FAIL glitch_reject got mode=%0d step=%b want mode=0 step=0", MODE, STEP);
    else passed++;
    SW_LEFT = 1'b0;
  endtask

  task automatic test_hazard_switch();
    int steps;
    bit after4;
    bit done;
    steps = 0; after4 = 0; done = 0;
    do_reset();
    SW_LEFT = 1'b1;
    for (int k = 0; k < 60 && !done; k++) begin
      tick();
      if (after4) begin
        total++;
        if (HAZ !== 1'b1 || MODE !== 2'd3 || LEFT !== 1'b0)
          $display("FAIL haz_after_frame got haz=%b mode=%0d left=%b want haz=1 mode=3 left=0", HAZ, MODE, LEFT);
        else passed++;
        done = 1;
      end else if (STEP === 1'b1) begin
        steps++;
        if (steps >= 2) begin
          total++;
          if (LEFT !== 1'b1 || HAZ !== 1'b0)
            $display("FAIL haz_frozen_step%0d got left=%b haz=%b want left=1 haz=0", steps, LEFT, HAZ);
          else passed++;
        end
        if (steps == 2) SW_HAZ = 1'b1;
        if (steps == 4) after4 = 1;
      end
    end
    if (!done) begin
      total++;
      $display("FAIL haz_timeout got steps=%0d want 4", steps);
    end
    SW_LEFT = 0; SW_HAZ = 0;
  endtask

  task automatic test_both();
    do_reset();
    SW_LEFT = 1'b1; SW_RIGHT = 1'b1;
    repeat (10) tick();
    total++;
    if (MODE !== 2'd3 || HAZ !== 1'b1 || LEFT !== 1'b0 || RIGHT !== 1'b0)
      $display("FAIL both_hazard got mode=%0d haz=%b left=%b right=%b want 3 1 0 0", MODE, HAZ, LEFT, RIGHT);
    else passed++;
    SW_LEFT = 0; SW_RIGHT = 0;
  endtask

  task automatic test_reset_mid_frame();
    bit seen;
    logic [6:0] got;
    seen = 0;
    do_reset();
    SW_RIGHT = 1'b1;
    for (int k = 0; k < 40 && !seen; k++) begin
      tick();
      if (STEP === 1'b1) seen = 1;
    end
    if (!seen) begin
      total++;
      $display("FAIL rst_mid_timeout got no STEP want STEP within 40 cycles");
    end
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    got = {MODE, LEFT, RIGHT, HAZ, STEP, BRAKE_OUT};
    total++;
    if (got !== 7'b0) $display("FAIL rst_mid_clear got=%b want=0000000", got);
    else passed++;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 5) begin
        total++;
        if (MODE !== 2'd0) $display("FAIL rst_mid_redebounce got mode=%0d want 0", MODE);
        else passed++;
      end
      if (k == 6) begin
        total++;
        if (MODE !== 2'd2 || RIGHT !== 1'b1)
          $display("FAIL rst_mid_restart got mode=%0d right=%b want mode=2 right=1", MODE, RIGHT);
        else passed++;
      end
    end
    SW_RIGHT = 1'b0;
  endtask

  task automatic test_brake();
    bit bad;
    bad = 0;
    do_reset();
    SW_BRAKE = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (MODE !== 2'd0) bad = 1;
      if (k == 4) begin
        total++;
        if (BRAKE_OUT !== 1'b0) $display("FAIL brake_c4 got=%b want=0", BRAKE_OUT);
        else passed++;
      end
      if (k == 5) begin
        total++;
        if (BRAKE_OUT !== BRAKE_EN) $display("FAIL brake_c5 got=%b want=%b", BRAKE_OUT, BRAKE_EN);
        else passed++;
      end
    end
    total++;
    if (bad) $display("FAIL brake_mode got mode=%0d want 0", MODE);
    else passed++;
    SW_BRAKE = 1'b0;
  endtask

  task automatic test_random();
    int         hold;
    logic [6:0] got;
    logic [6:0] want;
    do_reset();
    hold = 0;
    for (int k = 0; k < 1200; k++) begin
      if (hold == 0) begin
        SW_LEFT  = ($urandom_range(0, 2) == 0);
        SW_RIGHT = ($urandom_range(0, 2) == 0);
        SW_HAZ   = ($urandom_range(0, 4) == 0);
        SW_BRAKE = ($urandom_range(0, 1) == 0);
        hold     = $urandom_range(1, 12);
      end
      hold--;
      RESET = ($urandom_range(0, 149) == 0);
      tick();
      got  = {MODE, LEFT, RIGHT, HAZ, STEP, BRAKE_OUT};
      want = exp_vec();
      total++;
      if (got !== want) $display("FAIL random_c%0d got=%b want=%b", k, got, want);
      else passed++;
    end
    RESET = 1'b0;
  endtask

  initial begin
    test_reset();
    test_left_timing();
    test_glitch();
    test_hazard_switch();
    test_both();
    test_reset_mid_frame();
    test_brake();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
